// File: rtl/hid_act_stream.sv
// hid_act_stream: bias-add + saturate + ReLU on a captured hidden vector, streamed out as DATA_N-element beats
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/in_data/bias_in : vector capture pulse, packed elements and per-element bias
//   in_ready        : high while idle (ready to capture)
//   out_valid/out_ready/out_data/out_last : beat stream with valid/ready handshake
//   overrun         : sticky flag, an input pulse arrived while still streaming
module hid_act_stream #(
    parameter int BIT_LENGTH = 16,
    parameter int HID_LENGTH = 24,
    parameter int DATA_N     = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [HID_LENGTH*BIT_LENGTH-1:0] in_data,
    input  logic [HID_LENGTH*BIT_LENGTH-1:0] bias_in,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_N*BIT_LENGTH-1:0] out_data,
    output logic                         out_last,
    output logic                         overrun
);
    localparam int BEATS  = HID_LENGTH / DATA_N;
    localparam int BW     = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int BEAT_W = DATA_N * BIT_LENGTH;

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state;
    logic [BW-1:0]     beat;
    logic [BEAT_W-1:0] vec [BEATS];
    logic [BEAT_W-1:0] act [BEATS];

    for (genvar g = 0; g < HID_LENGTH; g++) begin : g_act
        logic [BIT_LENGTH-1:0] x, b;
        logic [BIT_LENGTH:0]   s;
        assign x = in_data[g*BIT_LENGTH +: BIT_LENGTH];
        assign b = bias_in[g*BIT_LENGTH +: BIT_LENGTH];
        assign s = {x[BIT_LENGTH-1], x} + {b[BIT_LENGTH-1], b};
        // negative sum -> ReLU zero; non-negative sum with bit 15 set exceeds 32767 -> clamp
        assign act[g / DATA_N][(g % DATA_N)*BIT_LENGTH +: BIT_LENGTH] =
            s[BIT_LENGTH] ? '0 : s[BIT_LENGTH-1] ? {1'b0, {(BIT_LENGTH-1){1'b1}}} : s[BIT_LENGTH-1:0];
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == SEND;
    assign out_last  = state == SEND && beat == BW'(BEATS-1);
    assign out_data  = vec[beat];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            beat    <= '0;
            vec     <= '{default: '0};
            overrun <= 1'b0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                vec   <= act;
                state <= SEND;
                beat  <= '0;
            end
        end else begin
            if (in_valid) overrun <= 1'b1;
            if (out_ready) begin
                beat  <= out_last ? '0 : beat + 1'b1;
                state <= out_last ? IDLE : SEND;
            end
        end
    end
endmodule

// File: tb/tb_hid_act_stream.sv
// tb_hid_act_stream: directed and randomized check of hid_act_stream against a queue-based reference model
module tb_hid_act_stream;
    localparam int BL = 16;
    localparam int HL = 24;
    localparam int DN = 6;
    localparam int BT = HL / DN;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [HL*BL-1:0]  in_data = '0;
    logic [HL*BL-1:0]  bias_in = '0;
    logic              in_ready, out_valid, out_last, overrun;
    logic [DN*BL-1:0]  out_data;

    hid_act_stream dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .bias_in(bias_in),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .overrun(overrun)
    );

    always #5 clk = ~clk;

    logic [DN*BL-1:0] q[$];
    bit               ov_m;
    bit               clean;
    int               n_cmp;
    int               n_err;
    logic [DN*BL-1:0] e;

    task automatic chk(input string tag, input logic [DN*BL-1:0] got, input logic [DN*BL-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [BL-1:0] ref_act(input logic [BL-1:0] x, input logic [BL-1:0] b);
        int s;
        s = int'($signed(x)) + int'($signed(b));
        if (s > 32767) s = 32767;
        if (s < 0) s = 0;
        return s[BL-1:0];
    endfunction

    task automatic set_el(input int i, input int x, input int b);
        in_data[i*BL +: BL] = x[BL-1:0];
        bias_in[i*BL +: BL] = b[BL-1:0];
    endtask

    task automatic check_outs();
        chk("in_ready", in_ready, q.size() == 0);
        chk("out_valid", out_valid, q.size() != 0);
        chk("overrun", overrun, ov_m);
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0]);
            chk("out_last", out_last, q.size() == 1);
        end else begin
            chk("out_last_idle", out_last, 0);
            if (clean) chk("out_data_clear", out_data, 0);
        end
    endtask

    task automatic cyc(input bit r, input bit iv, input bit ordy);
        logic [DN*BL-1:0] bb;
        rst = r;
        in_valid = iv;
        out_ready = ordy;
        @(posedge clk);
        if (r) begin
            q.delete();
            ov_m = 0;
            clean = 1;
        end else if (q.size() == 0) begin
            if (iv) begin
                clean = 0;
                for (int k = 0; k < BT; k++) begin
                    for (int j = 0; j < DN; j++)
                        bb[j*BL +: BL] = ref_act(in_data[(k*DN+j)*BL +: BL], bias_in[(k*DN+j)*BL +: BL]);
                    q.push_back(bb);
                end
            end
        end else begin
            if (iv) ov_m = 1;
            if (ordy) void'(q.pop_front());
        end
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        check_outs();
    endtask

    task automatic clear_vec();
        in_data = '0;
        bias_in = '0;
    endtask

    task automatic order_vec();
        for (int i = 0; i < HL; i++) set_el(i, i + 1, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc(1, 0, 0);
        cyc(1, 1, 1);
        cyc(0, 0, 1);

        clear_vec();
        set_el(0, -3, 5);
        set_el(1, -5, 2);
        set_el(2, 100, 0);
        cyc(0, 1, 1);
        e = '0;
        e[15:0] = 16'd2;
        e[47:32] = 16'd100;
        chk("basic_beat0", out_data, e);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1);
        chk("basic_idle_c5", in_ready, 1);

        clear_vec();
        set_el(0, 32767, 1);
        set_el(1, -32768, -1);
        set_el(6, 20000, 20000);
        cyc(0, 1, 1);
        e = '0;
        e[15:0] = 16'h7fff;
        chk("sat_beat0", out_data, e);
        cyc(0, 0, 1);
        chk("sat_beat1", out_data, e);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1);

        order_vec();
        cyc(0, 1, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1);

        order_vec();
        cyc(0, 1, 1);
        cyc(0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0);
        for (int j = 0; j < DN; j++) e[j*BL +: BL] = BL'(7 + j);
        chk("bp_hold", out_data, e);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1);
        chk("bp_done", in_ready, 1);

        order_vec();
        cyc(0, 1, 1);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        for (int i = 0; i < HL; i++) set_el(i, 9, 0);
        cyc(0, 1, 1);
        cyc(0, 1, 1);
        chk("ovr_sticky", overrun, 1);
        cyc(0, 0, 1);
        cyc(0, 1, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1);

        order_vec();
        cyc(0, 1, 1);
        cyc(0, 0, 1);
        cyc(1, 0, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        cyc(0, 1, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1);

        for (int n = 0; n < 3000; n++) begin
            bit iv;
            iv = $urandom_range(3) == 0;
            if (iv) begin
                for (int i = 0; i < HL; i++) begin
                    in_data[i*BL +: BL] = BL'($urandom);
                    bias_in[i*BL +: BL] = BL'($urandom);
                end
            end
            cyc($urandom_range(63) == 0, iv, $urandom_range(3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hid_act_stream.md
# hid_act_stream

Post-dot-product stage for the hidden layer. It captures the 24-element hidden vector from `main_dotv2` when that block's `valid` pulses. It adds a per-element bias with saturation and applies ReLU. It then streams the result as DATA_N-wide beats under a valid/ready handshake, so the next dot stage can consume it with the same chunk width used for `data_in`.

## Interface
- `BIT_LENGTH`, 16, element width; signed two's complement.
- `HID_LENGTH`, 24, elements per hidden vector.
- `DATA_N`, 6, elements per output beat. HID_LENGTH must be a multiple of DATA_N. BEATS = HID_LENGTH/DATA_N = 4.
- `clk  in  1`  system clock; all logic on the rising edge.
- `rst  in  1`  reset, synchronous, active-high.
- `in_valid  in  1`  connects to `main_dotv2.valid`; single-cycle pulse, no backpressure upstream.
- `in_data  in  HID_LENGTH*BIT_LENGTH`  connects to `main_dotv2.data_out`; element i is at [16i+15:16i].
- `bias_in  in  HID_LENGTH*BIT_LENGTH`  per-element bias, same packing; sampled together with `in_data`.
- `in_ready  out  1`  high when the block is in IDLE.
- `out_valid  out  1`  beat available.
- `out_ready  in  1`  downstream accepts the beat.
- `out_data  out  DATA_N*BIT_LENGTH`  beat k carries elements 6k..6k+5; element 6k+j is at [16j+15:16j].
- `out_last  out  1`  high with the final beat (k = BEATS-1).
- `overrun  out  1`  sticky; set when `in_valid` arrives while not IDLE.

## Operation
- FSM has two states, IDLE and SEND, plus beat counter `beat` of width clog2(BEATS). Output `in_ready` = (state==IDLE).
- **Capture.** Capture happens in IDLE when `in_valid`=1.
  - Each element is computed as y_i = relu(sat16(x_i + b_i)).
  - The add is 17-bit signed and saturates to [-32768, 32767]. ReLU then maps negative values to 0.
  - All 24 results are registered into `buf` on the same edge.
  - On that edge: state→SEND and beat→0.
- **SEND.**
  - `out_valid`=1.
  - `out_data` = `buf` elements [DATA_N*beat .. DATA_N*beat+DATA_N-1].
  - `out_last` = (beat==BEATS-1).
- **Handshake.** A beat transfers on an edge with `out_valid`&&`out_ready`; then beat increments.
  - A transfer with beat==BEATS-1 moves state→IDLE and beat→0.
  - With `out_ready`=0, `out_data`, `out_last` and `beat` hold unchanged. `out_valid` never drops mid-vector.
- **Overrun.** `in_valid`=1 while state==SEND sets `overrun`=1.
  - The input is dropped; `buf` and the stream are unaffected.
  - This includes the cycle of the last-beat transfer: state is still SEND, so the input is dropped.
  - `overrun` clears only on `rst`.
- **Reset.** On a `rst` edge: state=IDLE, beat=0, `buf`=0, `overrun`=0.
  - This holds from any state, including mid-vector; the partial vector is discarded without `out_last`.
  - `in_valid` is ignored during a `rst` cycle.
- **Reset values of outputs.** `in_ready`=1, `out_valid`=0, `out_data`=0, `out_last`=0, `overrun`=0.

## Timing
- Capture edge C: state→SEND. `out_valid`=1 and beat 0 are visible in cycle C+1, so latency is one cycle from capture to first beat.
- With `out_ready` held high, beats 0..3 appear in cycles C+1..C+4, with `out_last` in C+4. State is IDLE and `in_ready`=1 in C+5.
- Minimum spacing between accepted `in_valid` pulses is BEATS+1 = 5 cycles. `main_dotv2` produces at most one vector per 8 input cycles, so overrun indicates a stalled consumer.
- No combinational path from `out_ready` or `in_valid` to any output. `in_ready` depends on state only.
- Each `out_ready`=0 cycle adds exactly one cycle of latency to the remaining beats.

## Test plan
- **Basic arithmetic.** Pulse `in_valid` with x0=-3, b0=5; x1=-5, b1=2; x2=100, b2=0; other elements 0/0; `out_ready`=1.
  - Beat 0 element0=2, element1=0, element2=100, rest 0. Beats 1–3 all zero.
  - `out_last` only on the 4th beat; `in_ready` returns 1 five cycles after capture.
- **Saturation.** x0=32767, b0=1 → element0=32767. x1=-32768, b1=-1 → element1=0.
  - x6=20000, b6=20000 → beat 1 element0=32767.
- **Element ordering.** x_i=i+1, b_i=0.
  - Beats are {1..6}, {7..12}, {13..18}, {19..24}, with the lowest element in the LSBs.
- **Backpressure.** Hold `out_ready`=0 for 3 cycles while beat 1 is presented.
  - `out_data` stays {7..12} with `out_valid`=1. The stream completes 3 cycles later, with no beat lost or duplicated.
- **Overrun.** Pulse `in_valid` (second vector all 9) during beat 2.
  - `overrun`=1 and stays; the first vector completes unchanged. The second vector is never emitted.
  - A fresh pulse after return to IDLE streams normally.
- **Reset mid-stream.** Assert `rst` for one cycle during beat 1.
  - Next cycle `out_valid`=0, `out_data`=0, `in_ready`=1, `overrun`=0.
  - A following vector streams from beat 0.
